car_sensor_fsm: RTL and testbench

// - Front end of the parking-lot occupancy path: turns two raw photo-sensor lines into car-event pulses.
// - Sensor A sits on the outer side of the gate and sensor B on the inner side.
// - Sequence A, AB, B, clear = one car entered; B, AB, A, clear = one car left.
// - Outputs car_in/car_out are single-cycle pulses that drive the occupancy counter's incr/decr directly.

---
 rtl/car_sensor_fsm.sv | 65 ++++++
 tb/tb_car_sensor_fsm.sv | 132 +++++++++++++
 2 files changed

// File: rtl/car_sensor_fsm.sv
// car_sensor_fsm: synchronizes and debounces two gate sensors and emits one-cycle car entry/exit pulses.
module car_sensor_fsm #(
  parameter int DEBOUNCE = 4,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic car_in,
  output logic car_out,
  output logic busy,
  output logic fault
);
  typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR} state_t;
  state_t state;
  logic [1:0] s1, s2, f;
  logic [CW-1:0] cnt [2];
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      f <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= {a_raw, b_raw};
      s2 <= s1;
      for (int i = 0; i < 2; i++)
        if (s2[i] == f[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
          f[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
    end
  end
  // f = {A, B}; any pattern not listed for a state is a protocol violation
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      car_in <= 1'b0;
      car_out <= 1'b0;
    end else begin
      car_in <= 1'b0;
      car_out <= 1'b0;
      case (state)
        IDLE:    state <= f == 2'b00 ? IDLE : f == 2'b10 ? IN_A : f == 2'b01 ? OUT_B : WAIT_CLEAR;
        IN_A:    state <= f == 2'b10 ? IN_A : f == 2'b11 ? IN_AB : f == 2'b00 ? IDLE : WAIT_CLEAR;
        IN_AB:   state <= f == 2'b11 ? IN_AB : f == 2'b01 ? IN_B : f == 2'b10 ? IN_A : WAIT_CLEAR;
        IN_B: begin
          state <= f == 2'b01 ? IN_B : f == 2'b00 ? IDLE : f == 2'b11 ? IN_AB : WAIT_CLEAR;
          car_in <= f == 2'b00;
        end
        OUT_B:   state <= f == 2'b01 ? OUT_B : f == 2'b11 ? OUT_AB : f == 2'b00 ? IDLE : WAIT_CLEAR;
        OUT_AB:  state <= f == 2'b11 ? OUT_AB : f == 2'b10 ? OUT_A : f == 2'b01 ? OUT_B : WAIT_CLEAR;
        OUT_A: begin
          state <= f == 2'b10 ? OUT_A : f == 2'b00 ? IDLE : f == 2'b11 ? OUT_AB : WAIT_CLEAR;
          car_out <= f == 2'b00;
        end
        default: state <= f == 2'b00 ? IDLE : WAIT_CLEAR;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign fault = state == WAIT_CLEAR;
endmodule

// File: tb/tb_car_sensor_fsm.sv
// tb_car_sensor_fsm: directed scenarios for car_sensor_fsm with DEBOUNCE=2.
module tb_car_sensor_fsm;
  logic clk = 1'b0, reset = 1'b1, a_raw = 1'b0, b_raw = 1'b0;
  logic car_in, car_out, busy, fault;
  int n_cmp = 0, n_bad = 0;
  int ci_tot = 0, co_tot = 0, busy_tot = 0, both_tot = 0;
  int ci0, co0, b0;
  car_sensor_fsm #(.DEBOUNCE(2), .CW(2)) dut (
    .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
    .car_in(car_in), .car_out(car_out), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (car_in === 1'b1) ci_tot++;
    if (car_out === 1'b1) co_tot++;
    if (busy === 1'b1) busy_tot++;
    if (car_in === 1'b1 && car_out === 1'b1) both_tot++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic a, input logic b, input int n);
    a_raw = a;
    b_raw = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic snap();
    ci0 = ci_tot;
    co0 = co_tot;
    b0 = busy_tot;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_car_in", car_in, 0);
    chk("rst_car_out", car_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    // entry with exact pulse latency
    snap();
    drive(0, 0, 6);
    drive(1, 0, 6);
    chk("entry_in_a_busy", busy, 1);
    drive(1, 1, 6);
    drive(0, 1, 6);
    drive(0, 0, 4);
    chk("entry_pulse_early", car_in, 0);
    chk("entry_busy_before", busy, 1);
    drive(0, 0, 1);
    chk("entry_pulse_edge5", car_in, 1);
    chk("entry_out_quiet", car_out, 0);
    chk("entry_idle", busy, 0);
    drive(0, 0, 1);
    chk("entry_pulse_width", car_in, 0);
    drive(0, 0, 4);
    chk("entry_ci_count", ci_tot - ci0, 1);
    chk("entry_co_count", co_tot - co0, 0);
    // exit
    snap();
    drive(0, 1, 6);
    chk("exit_out_b_busy", busy, 1);
    drive(1, 1, 6);
    chk("exit_out_ab_busy", busy, 1);
    drive(1, 0, 6);
    drive(0, 0, 4);
    chk("exit_busy_before", busy, 1);
    chk("exit_pulse_early", car_out, 0);
    drive(0, 0, 1);
    chk("exit_pulse_edge5", car_out, 1);
    chk("exit_idle", busy, 0);
    drive(0, 0, 5);
    chk("exit_co_count", co_tot - co0, 1);
    chk("exit_ci_count", ci_tot - ci0, 0);
    // back-out
    snap();
    drive(1, 0, 6);
    drive(1, 1, 6);
    drive(1, 0, 6);
    drive(0, 0, 6);
    chk("backout_ci", ci_tot - ci0, 0);
    chk("backout_co", co_tot - co0, 0);
    chk("backout_idle", busy, 0);
    // glitches
    snap();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1);
      drive(0, 0, 3);
    end
    drive(0, 0, 4);
    chk("glitch_busy_cycles", busy_tot - b0, 0);
    chk("glitch_ci", ci_tot - ci0, 0);
    // both sensors qualify together
    snap();
    drive(1, 1, 6);
    chk("illegal_fault", fault, 1);
    chk("illegal_busy", busy, 1);
    drive(0, 0, 6);
    chk("illegal_fault_clear", fault, 0);
    chk("illegal_idle", busy, 0);
    chk("illegal_ci", ci_tot - ci0, 0);
    chk("illegal_co", co_tot - co0, 0);
    snap();
    drive(1, 0, 6);
    drive(1, 1, 6);
    drive(0, 1, 6);
    drive(0, 0, 6);
    chk("post_illegal_ci", ci_tot - ci0, 1);
    // reset while in IN_AB
    drive(1, 0, 6);
    drive(1, 1, 6);
    chk("midrst_busy_before", busy, 1);
    snap();
    reset = 1'b1;
    drive(0, 0, 1);
    reset = 1'b0;
    chk("midrst_car_in", car_in, 0);
    chk("midrst_car_out", car_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fault", fault, 0);
    drive(0, 0, 10);
    chk("midrst_no_ci", ci_tot - ci0, 0);
    chk("midrst_idle", busy, 0);
    chk("never_both", both_tot, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
